t08_mem_arbiter: RTL and testbench

//  Shares the single memory bus-master port between NREQ requesters.

---
 rtl/t08_arb_pkg.sv | 20 ++
 rtl/t08_rr_picker.sv | 51 +++++
 rtl/t08_mem_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_t08_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t08_arb_pkg.sv
// ----------------------------------------------------------------------------
// t08_arb_pkg
//   Shared types and constants for the memory-port arbiter.
//   - arb_state_t  : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   - ARB_ERR_DATA : load data returned on a timeout abort
//   - ARB_GRANT_W  : width of the grant index (covers up to 8 requesters)
// ----------------------------------------------------------------------------
package t08_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          ARB_GRANT_W  = 3;

endpackage

// File: rtl/t08_rr_picker.sv
// ----------------------------------------------------------------------------
// t08_rr_picker
//   Combinational round-robin selector. Starting one position after i_ptr
//   and wrapping around, returns the first asserted bit of i_valid.
// Ports
//   i_valid  [NREQ-1:0]  request vector
//   i_ptr    [2:0]       index of the previous winner (must be < NREQ)
//   o_onehot [NREQ-1:0]  one-hot winner (all zero when nothing is valid)
//   o_idx    [2:0]       binary index of the winner
//   o_any                at least one request is valid
// ----------------------------------------------------------------------------
module t08_rr_picker
    import t08_arb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]        i_valid,
    input  logic [ARB_GRANT_W-1:0] i_ptr,
    output logic [NREQ-1:0]        o_onehot,
    output logic [ARB_GRANT_W-1:0] o_idx,
    output logic                   o_any
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    always_comb begin
        int   pos;
        logic found;
        // NOTE: every variable written here gets a default before the search,
        // so no path leaves a value held over and no latch is inferred.
        o_onehot = '0;
        o_idx    = '0;
        pos      = 0;
        found    = 1'b0;
        // The previous winner is visited last, which is what makes it fair.
        for (int k = 1; k <= NREQ; k++) begin
            pos = int'(i_ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && i_valid[pos[IW-1:0]]) begin
                found                  = 1'b1;
                o_onehot[pos[IW-1:0]] = 1'b1;
                o_idx                  = ARB_GRANT_W'(pos);
            end
        end
    end

    assign o_any = |i_valid;

endmodule

// File: rtl/t08_mem_arbiter.sv
// ----------------------------------------------------------------------------
// t08_mem_arbiter
//   Shares one bus-master port between NREQ requesters (0: load/store,
//   1: instruction fetch, 2: peripheral engine). One transaction at a time,
//   round-robin grant, one-cycle accept and completion pulses per port.
//   Flow: IDLE (grant) -> ISSUE (one-cycle strobe) -> WAIT (guard cycle,
//   then wait for bus_busy low) -> RESP (completion pulse) -> IDLE.
//
// Optional feature: define T08_ARB_TIMEOUT_EN to bound WAIT at TIMEOUT_CYC
//   cycles; an expired wait completes with rsp_err=1 and rsp_rdata=DEAD_BEEF.
//   Without the macro there is no counter and rsp_err is constant 0.
//
// Ports
//   clk, nrst                 clock, asynchronous active-low reset
//   req_valid/req_write [N]   per-port request and direction (1 = store)
//   req_addr  [N*AW]          per-port byte address
//   req_wdata [N*DW]          per-port store data
//   req_sel   [N*4]           per-port byte-lane enables
//   req_ready [N]             one-hot accept pulse
//   rsp_valid [N]             one-hot completion pulse
//   rsp_rdata [DW]            load data, valid with rsp_valid
//   rsp_err                   completion was a timeout abort
//   bus_read/bus_write        one-cycle bus strobes
//   bus_addr/bus_wdata/bus_sel latched transaction fields
//   bus_rdata, bus_busy       bus manager read data and busy flag
//   grant_id  [3]             index of the port owning the bus
// ----------------------------------------------------------------------------
module t08_mem_arbiter
    import t08_arb_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int AW          = 32,
    parameter int DW          = 32
`ifdef T08_ARB_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*4-1:0]      req_sel,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   rsp_err,
    output logic                   bus_read,
    output logic                   bus_write,
    output logic [AW-1:0]          bus_addr,
    output logic [DW-1:0]          bus_wdata,
    output logic [3:0]             bus_sel,
    input  logic [DW-1:0]          bus_rdata,
    input  logic                   bus_busy,
    output logic [ARB_GRANT_W-1:0] grant_id
);

    arb_state_t             r_state;
    arb_state_t             w_next;

    logic [NREQ-1:0]        r_req_ready;
    logic [NREQ-1:0]        r_rsp_valid;
    logic [DW-1:0]          r_rsp_rdata;
    logic                   r_bus_read;
    logic                   r_bus_write;
    logic [AW-1:0]          r_bus_addr;
    logic [DW-1:0]          r_bus_wdata;
    logic [3:0]             r_bus_sel;
    logic [ARB_GRANT_W-1:0] r_grant_id;
    logic [NREQ-1:0]        r_grant_oh;
    logic [ARB_GRANT_W-1:0] r_rr_ptr;
    logic                   r_write;
    logic                   r_guard;     // set for the first WAIT cycle only

    logic [NREQ-1:0]        w_win_oh;
    logic [ARB_GRANT_W-1:0] w_win_idx;
    logic                   w_any;
    logic                   w_win_write;
    logic                   w_grant;
    logic                   w_done;

`ifdef T08_ARB_TIMEOUT_EN
    logic [7:0]             r_tcnt;
    logic                   r_rsp_err;
    logic                   w_tmo;
`endif

    t08_rr_picker #(.NREQ(NREQ)) u_picker (
        .i_valid  (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_any    (w_any)
    );

    // Direction of the winning port, taken through the one-hot mask so no
    // index wider than the vector is needed.
    assign w_win_write = |(req_write & w_win_oh);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_done  = 1'b0;
`ifdef T08_ARB_TIMEOUT_EN
        w_tmo   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_any && !bus_busy) begin
                    w_grant = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                // The bus manager may not have raised busy yet in the first
                // WAIT cycle, so bus_busy is only trusted from the second.
                if (!r_guard && !bus_busy) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end
`ifdef T08_ARB_TIMEOUT_EN
                else if (r_tcnt == 8'(TIMEOUT_CYC - 1)) begin
                    w_tmo  = 1'b1;
                    w_next = RESP;
                end
`endif
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_sel   <= '0;
            r_grant_id  <= '0;
            r_grant_oh  <= '0;
            r_rr_ptr    <= ARB_GRANT_W'(NREQ - 1);   // port 0 wins first
            r_write     <= 1'b0;
            r_guard     <= 1'b0;
`ifdef T08_ARB_TIMEOUT_EN
            r_tcnt      <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            // Pulses default low and are raised only on their event.
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
`ifdef T08_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif

            if (w_grant) begin
                r_req_ready <= w_win_oh;
                r_grant_oh  <= w_win_oh;
                r_grant_id  <= w_win_idx;
                r_rr_ptr    <= w_win_idx;
                r_write     <= w_win_write;
                r_bus_read  <= !w_win_write;
                r_bus_write <= w_win_write;
                r_bus_addr  <= req_addr[w_win_idx*AW +: AW];
                r_bus_wdata <= req_wdata[w_win_idx*DW +: DW];
                r_bus_sel   <= req_sel[w_win_idx*4 +: 4];
            end

            if (r_state == ISSUE) begin
                r_guard <= 1'b1;
`ifdef T08_ARB_TIMEOUT_EN
                r_tcnt  <= '0;
`endif
            end

            if (r_state == WAIT) begin
                r_guard <= 1'b0;
`ifdef T08_ARB_TIMEOUT_EN
                r_tcnt  <= r_tcnt + 8'd1;
`endif
            end

            // Stores complete too, but leave the last load data in place.
            if (w_done) begin
                r_rsp_valid <= r_grant_oh;
                if (!r_write) begin
                    r_rsp_rdata <= bus_rdata;
                end
            end

`ifdef T08_ARB_TIMEOUT_EN
            if (w_tmo) begin
                r_rsp_valid <= r_grant_oh;
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= DW'(ARB_ERR_DATA);
            end
`endif
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign bus_read  = r_bus_read;
    assign bus_write = r_bus_write;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_sel   = r_bus_sel;
    assign grant_id  = r_grant_id;
`ifdef T08_ARB_TIMEOUT_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_t08_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_t08_mem_arbiter
//   Directed bench for t08_mem_arbiter (NREQ=3). A table of single-port
//   transactions drives the main load/store path; hand-written sequences
//   cover round-robin order, busy-in-IDLE, withdrawal, reset mid-WAIT and,
//   when T08_ARB_TIMEOUT_EN is defined, the timeout abort.
// ----------------------------------------------------------------------------
module tb_t08_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                nrst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_write;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ*4-1:0]   req_sel;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_err;
    logic                bus_read;
    logic                bus_write;
    logic [AW-1:0]       bus_addr;
    logic [DW-1:0]       bus_wdata;
    logic [3:0]          bus_sel;
    logic [DW-1:0]       bus_rdata;
    logic                bus_busy;
    logic [2:0]          grant_id;

    always #5 clk = ~clk;

    t08_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_rdata (bus_rdata),
        .bus_busy  (bus_busy),
        .grant_id  (grant_id)
    );

    typedef struct {
        logic [1:0]  port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          busy_n;     // cycles bus_busy stays high after the strobe
        logic [31:0] bus_rd;     // bus_rdata presented when busy falls
        int          exp_lat;    // req_ready -> rsp_valid, in cycles
        logic [31:0] exp_rdata;  // rsp_rdata during rsp_valid
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input logic [1:0] p, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        req_write[p]          = wr;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
        req_sel[p*4 +: 4]     = s;
        req_valid[p]          = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (req_ready == '0 && n < 10) begin
            tick();
            n++;
        end
        check({tag, " ready seen"}, 32'(|req_ready), 32'd1);
    endtask

    task automatic wait_rsp(input int budget, output int lat);
        lat = 0;
        while (rsp_valid == '0 && lat < budget) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [NREQ-1:0] oh;
        int              lat;
        string           tag;
        tag      = $sformatf("vec%0d", i);
        oh       = '0;
        oh[v.port] = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        set_port(v.port, v.wr, v.addr, v.wdata, v.sel);
        wait_ready(tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'(oh));
        check({tag, " grant_id"},  32'(grant_id),  32'(v.port));
        check({tag, " bus_read"},  32'(bus_read),  32'(!v.wr));
        check({tag, " bus_write"}, 32'(bus_write), 32'(v.wr));
        check({tag, " bus_addr"},  bus_addr,       v.addr);
        if (v.wr) begin
            check({tag, " bus_wdata"}, bus_wdata,     v.wdata);
            check({tag, " bus_sel"},   32'(bus_sel),  32'(v.sel));
        end
        req_valid = '0;
        bus_busy  = (v.busy_n > 0);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == v.busy_n + 1) begin
                bus_busy  = 1'b0;
                bus_rdata = v.bus_rd;
            end
            tick();
            if (c == 1) begin
                check({tag, " strobes one cycle"}, 32'({bus_read, bus_write}), 32'd0);
            end
            if (rsp_valid != '0) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"},   32'(lat),       32'(v.exp_lat));
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
        check({tag, " rsp_rdata"}, rsp_rdata,      v.exp_rdata);
        check({tag, " rsp_err"},   32'(rsp_err),   32'd0);
        tick();
        check({tag, " rsp pulse one cycle"}, 32'(rsp_valid), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int lat;

        vecs[0] = '{2'd1, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 2, 32'h1234_5678, 3, 32'h1234_5678};
        vecs[1] = '{2'd0, 1'b1, 32'h0000_07FC, 32'hCAFE_F00D, 4'h3, 1, 32'h5555_5555, 3, 32'h1234_5678};
        vecs[2] = '{2'd0, 1'b0, 32'h0000_0200, 32'h0,         4'hF, 0, 32'h89AB_CDEF, 3, 32'h89AB_CDEF};
        vecs[3] = '{2'd2, 1'b0, 32'h0000_0003, 32'h0,         4'h1, 5, 32'hA5A5_0F0F, 6, 32'hA5A5_0F0F};
        vecs[4] = '{2'd2, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 0, 32'h1111_1111, 3, 32'hA5A5_0F0F};

        nrst      = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_sel   = '0;
        bus_rdata = '0;
        bus_busy  = 1'b0;
        tick();
        tick();
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata,      32'd0);
        check("reset rsp_err",   32'(rsp_err),   32'd0);
        check("reset strobes",   32'({bus_read, bus_write}), 32'd0);
        check("reset bus_addr",  bus_addr,       32'd0);
        check("reset bus_wdata", bus_wdata,      32'd0);
        check("reset bus_sel",   32'(bus_sel),   32'd0);
        check("reset grant_id",  32'(grant_id),  32'd0);
        nrst = 1'b1;
        tick();

        // Single-port loads and stores from the table.
        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // Round robin: all three ports held valid; last winner was port 2.
        for (int p = 0; p < NREQ; p++) begin
            set_port(2'(p), 1'b0, 32'h0000_1000 + 32'(p * 4), 32'h0, 4'hF);
        end
        for (int k = 0; k < 6; k++) begin
            logic [NREQ-1:0] oh;
            oh = '0;
            oh[k % NREQ] = 1'b1;
            bus_rdata = 32'h0000_1000 + 32'(k);
            wait_ready($sformatf("rr%0d", k));
            check($sformatf("rr%0d grant_id", k),  32'(grant_id),  32'(k % NREQ));
            check($sformatf("rr%0d req_ready", k), 32'(req_ready), 32'(oh));
            check($sformatf("rr%0d bus_addr", k),  bus_addr,       32'h0000_1000 + 32'((k % NREQ) * 4));
            wait_rsp(10, lat);
            check($sformatf("rr%0d latency", k),   32'(lat),       32'd3);
            check($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), 32'(oh));
            check($sformatf("rr%0d rsp_rdata", k), rsp_rdata,      32'h0000_1000 + 32'(k));
            tick();
        end
        req_valid = '0;
        tick();

        // bus_busy high in IDLE blocks the grant; port 1 withdraws meanwhile.
        bus_busy = 1'b1;
        set_port(2'd2, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        set_port(2'd1, 1'b0, 32'h0000_0310, 32'h0, 4'hF);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("busy idle c%0d no ready", c), 32'(req_ready), 32'd0);
        end
        req_valid[1] = 1'b0;
        bus_busy     = 1'b0;
        bus_rdata    = 32'h3000_0003;
        tick();
        check("busy release req_ready", 32'(req_ready), 32'b100);
        check("busy release grant_id",  32'(grant_id),  32'd2);
        req_valid = '0;
        wait_rsp(10, lat);
        check("busy release rsp_valid", 32'(rsp_valid), 32'b100);
        check("busy release rsp_rdata", rsp_rdata,      32'h3000_0003);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("withdrawn c%0d no ready", c), 32'(req_ready), 32'd0);
        end

        // Reset while in WAIT: everything clears, port 0 wins afterwards.
        set_port(2'd1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        wait_ready("rst txn");
        check("rst txn grant_id", 32'(grant_id), 32'd1);
        req_valid = '0;
        bus_busy  = 1'b1;
        tick();
        tick();
        #2;
        nrst = 1'b0;
        #1;
        check("rst mid req_ready", 32'(req_ready), 32'd0);
        check("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst mid strobes",   32'({bus_read, bus_write}), 32'd0);
        check("rst mid bus_addr",  bus_addr,       32'd0);
        check("rst mid rsp_rdata", rsp_rdata,      32'd0);
        check("rst mid grant_id",  32'(grant_id),  32'd0);
        tick();
        check("rst held rsp_valid", 32'(rsp_valid), 32'd0);
        nrst     = 1'b1;
        bus_busy = 1'b0;
        bus_rdata = 32'h0BAD_CAFE;
        for (int p = 0; p < NREQ; p++) begin
            set_port(2'(p), 1'b0, 32'h0000_2000 + 32'(p * 4), 32'h0, 4'hF);
        end
        wait_ready("post rst");
        check("post rst grant_id",  32'(grant_id),  32'd0);
        check("post rst req_ready", 32'(req_ready), 32'b001);
        req_valid = '0;
        wait_rsp(10, lat);
        check("post rst rsp_valid", 32'(rsp_valid), 32'b001);
        check("post rst rsp_rdata", rsp_rdata,      32'h0BAD_CAFE);
        tick();

`ifdef T08_ARB_TIMEOUT_EN
        // bus_busy stuck high: abort after 255 WAIT cycles (ISSUE + 255).
        set_port(2'd0, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
        wait_ready("tmo");
        req_valid = '0;
        bus_busy  = 1'b1;
        wait_rsp(400, lat);
        check("tmo latency",   32'(lat),       32'd256);
        check("tmo rsp_valid", 32'(rsp_valid), 32'b001);
        check("tmo rsp_err",   32'(rsp_err),   32'd1);
        check("tmo rsp_rdata", rsp_rdata,      32'hDEAD_BEEF);
        bus_busy = 1'b0;
        tick();
        check("tmo err pulse", 32'(rsp_err),   32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
